// File: rtl/branch_history_predictor_pkg.sv
// Shared constants and types for the 2-bit-counter branch predictor.
// Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
package branch_history_predictor_pkg;

    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [1:0] SNT          = 2'b00;
    localparam logic [1:0] WNT          = 2'b01;
    localparam logic [1:0] WT           = 2'b10;
    localparam logic [1:0] ST           = 2'b11;
    localparam int         IDX_MAX_BITS = 16;

    // Stage index is stored zero-extended so the struct does not depend on IDX_BITS
    typedef struct packed {
        logic                    valid;
        logic                    pred;
        logic [IDX_MAX_BITS-1:0] idx;
    } stage_t;

    localparam stage_t STAGE_CLR = '{valid: 1'b0, pred: 1'b0, idx: {IDX_MAX_BITS{1'b0}}};

    function automatic logic is_branch(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/branch_history_predictor_sat.sv
// 2-bit saturating up/down counter next-state function for the table write path.
module sat_counter2
    import branch_history_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       up_i,
    output logic [1:0] cnt_o
);

    // Saturating increment toward ST or decrement toward SNT
    always_comb begin
        cnt_o = cnt_i;
        if (up_i) begin
            case (cnt_i)
                SNT:     cnt_o = WNT;
                WNT:     cnt_o = WT;
                WT:      cnt_o = ST;
                ST:      cnt_o = ST;
                default: cnt_o = WNT;
            endcase
        end else begin
            case (cnt_i)
                SNT:     cnt_o = SNT;
                WNT:     cnt_o = SNT;
                WT:      cnt_o = WNT;
                ST:      cnt_o = WT;
                default: cnt_o = WNT;
            endcase
        end
    end

endmodule

// File: rtl/branch_history_predictor.sv
// Dynamic branch predictor: PC-indexed table of 2-bit counters looked up at IF,
// guess carried through ID to EX, trained at EX resolution with statistics.
module branch_history_predictor
    import branch_history_predictor_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_if,
    input  logic [31:0]      inst_if,
    input  logic             stall,
    input  logic [1:0]       flush,
    output logic             prediction_if,
    output logic             prediction,
    output logic             branch_ex,
    input  logic             upd_valid,
    input  logic             upd_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          table_q [ENTRIES];
    stage_t              id_q, id_d;
    stage_t              ex_q, ex_d;
    logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]    mispred_cnt_q, mispred_cnt_d;

    logic [IDX_BITS-1:0] idx_if_s;
    logic [IDX_BITS-1:0] idx_ex_s;
    logic                is_br_s;
    logic                train_s;
    logic [1:0]          cnt_ex_s;
    logic [1:0]          cnt_next_s;
    logic                unused_s;

    assign idx_if_s      = pc_if[IDX_BITS+1:2];
    assign is_br_s       = is_branch(inst_if[6:0]);
    assign prediction_if = is_br_s & table_q[idx_if_s][1];

    assign idx_ex_s = ex_q.idx[IDX_BITS-1:0];
    assign cnt_ex_s = table_q[idx_ex_s];
    assign train_s  = upd_valid & ex_q.valid;

    assign unused_s = ^{pc_if[31:IDX_BITS+2], pc_if[1:0], inst_if[31:7],
                        ex_q.idx[IDX_MAX_BITS-1:IDX_BITS], id_q.idx[IDX_MAX_BITS-1:IDX_BITS]};

    sat_counter2 u_sat (
        .cnt_i (cnt_ex_s),
        .up_i  (upd_taken),
        .cnt_o (cnt_next_s)
    );

    // Stage-register next state: flush beats stall beats normal advance
    always_comb begin
        id_d = id_q;
        ex_d = ex_q;
        if (flush != 2'b00) begin
            id_d.valid = 1'b0;
            ex_d.valid = 1'b0;
        end else if (stall) begin
            ex_d.valid = 1'b0;
        end else begin
            id_d.valid = is_br_s;
            id_d.pred  = prediction_if;
            id_d.idx   = {{(IDX_MAX_BITS-IDX_BITS){1'b0}}, idx_if_s};
            ex_d       = id_q;
        end
    end

    // Statistics next state; training uses pre-edge EX contents even under flush
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (train_s) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
            if (upd_taken != ex_q.pred) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end else begin
                mispred_cnt_d = mispred_cnt_q;
            end
        end else begin
            branch_cnt_d  = branch_cnt_q;
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // Pipeline stage and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q          <= STAGE_CLR;
            ex_q          <= STAGE_CLR;
            branch_cnt_q  <= {CNT_W{1'b0}};
            mispred_cnt_q <= {CNT_W{1'b0}};
        end else begin
            id_q          <= id_d;
            ex_q          <= ex_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Counter table: all weak-NT after reset, single write port at EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= WNT;
            end
        end else if (train_s) begin
            table_q[idx_ex_s] <= cnt_next_s;
        end
    end

    assign prediction  = ex_q.valid & ex_q.pred;
    assign branch_ex   = ex_q.valid;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed bench for branch_history_predictor with hand-computed expectations.
module tb_branch_history_predictor;

    localparam logic [31:0] BR  = 32'h0000_0063;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic [31:0] inst_if;
    logic        stall;
    logic [1:0]  flush;
    logic        prediction_if;
    logic        prediction;
    logic        branch_ex;
    logic        upd_valid;
    logic        upd_taken;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    branch_history_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .pc_if         (pc_if),
        .inst_if       (inst_if),
        .stall         (stall),
        .flush         (flush),
        .prediction_if (prediction_if),
        .prediction    (prediction),
        .branch_ex     (branch_ex),
        .upd_valid     (upd_valid),
        .upd_taken     (upd_taken),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fetch one branch, let it reach EX, resolve it, then check statistics
    task automatic do_branch(input string tag, input logic [31:0] pc, input logic taken,
                             input logic exp_pred, input int exp_bc, input int exp_mc);
        pc_if = pc; inst_if = BR; stall = 1'b0; flush = 2'b00; upd_valid = 1'b0;
        #1;
        check({tag, "_pred_if"}, {31'd0, prediction_if}, {31'd0, exp_pred});
        tick();
        inst_if = NOP;
        tick();
        check({tag, "_branch_ex"}, {31'd0, branch_ex}, 32'd1);
        check({tag, "_prediction"}, {31'd0, prediction}, {31'd0, exp_pred});
        upd_valid = 1'b1; upd_taken = taken;
        tick();
        upd_valid = 1'b0;
        check({tag, "_branch_cnt"}, branch_cnt, exp_bc);
        check({tag, "_mispred_cnt"}, mispred_cnt, exp_mc);
    endtask

    initial begin
        rst = 1'b1; pc_if = 32'h100; inst_if = 32'd0; stall = 1'b0; flush = 2'b00;
        upd_valid = 1'b0; upd_taken = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_prediction", {31'd0, prediction}, 32'd0);
        check("rst_branch_ex", {31'd0, branch_ex}, 32'd0);
        check("rst_branch_cnt", branch_cnt, 32'd0);
        check("rst_mispred_cnt", mispred_cnt, 32'd0);

        // Dirty the state, then reset mid-run
        inst_if = BR;
        tick(); tick();
        check("pre_branch_ex", {31'd0, branch_ex}, 32'd1);
        upd_valid = 1'b1; upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        #1;
        check("pre_pred_if", {31'd0, prediction_if}, 32'd1);
        check("pre_branch_cnt", branch_cnt, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_branch_ex", {31'd0, branch_ex}, 32'd0);
        check("midrst_prediction", {31'd0, prediction}, 32'd0);
        check("midrst_branch_cnt", branch_cnt, 32'd0);
        check("midrst_mispred_cnt", mispred_cnt, 32'd0);
        check("midrst_pred_if", {31'd0, prediction_if}, 32'd0);
        tick();
        rst = 1'b0;
        inst_if = NOP;
        tick();

        // Training up then saturating down at index 0
        do_branch("A", 32'h100, 1'b1, 1'b0, 1, 1);
        do_branch("B", 32'h100, 1'b1, 1'b1, 2, 1);
        do_branch("C", 32'h100, 1'b0, 1'b1, 3, 2);
        do_branch("D", 32'h100, 1'b0, 1'b1, 4, 3);
        do_branch("E", 32'h100, 1'b0, 1'b0, 5, 3);
        do_branch("F", 32'h100, 1'b0, 1'b0, 6, 3);
        do_branch("G", 32'h100, 1'b1, 1'b0, 7, 4);

        // Non-branch at a trained-taken index; stray upd_valid is ignored
        do_branch("H", 32'h104, 1'b1, 1'b0, 8, 5);
        pc_if = 32'h104; inst_if = NOP;
        #1;
        check("nop_pred_if", {31'd0, prediction_if}, 32'd0);
        upd_valid = 1'b1; upd_taken = 1'b0;
        tick(); tick(); tick();
        upd_valid = 1'b0;
        check("nop_branch_ex", {31'd0, branch_ex}, 32'd0);
        check("nop_branch_cnt", branch_cnt, 32'd8);
        check("nop_mispred_cnt", mispred_cnt, 32'd5);
        do_branch("I", 32'h104, 1'b1, 1'b1, 9, 5);

        // Stall: branch held in ID, bubbles into EX
        pc_if = 32'h104; inst_if = BR;
        tick();
        stall = 1'b1; inst_if = NOP;
        tick();
        check("stall1_branch_ex", {31'd0, branch_ex}, 32'd0);
        tick();
        check("stall2_branch_ex", {31'd0, branch_ex}, 32'd0);
        stall = 1'b0;
        tick();
        check("unstall_branch_ex", {31'd0, branch_ex}, 32'd1);
        check("unstall_prediction", {31'd0, prediction}, 32'd1);
        tick();
        check("unstall_next_branch_ex", {31'd0, branch_ex}, 32'd0);

        // Flush kills a branch in ID
        inst_if = BR;
        tick();
        inst_if = NOP; flush = 2'b11;
        tick();
        flush = 2'b00;
        check("flush_branch_ex", {31'd0, branch_ex}, 32'd0);
        tick();
        check("flush_after_branch_ex", {31'd0, branch_ex}, 32'd0);
        check("flush_branch_cnt", branch_cnt, 32'd9);

        // Update + flush + same-index lookup in one cycle
        do_branch("J", 32'h104, 1'b0, 1'b1, 10, 6);
        pc_if = 32'h104; inst_if = BR;
        tick();
        inst_if = NOP;
        tick();
        check("sim_branch_ex", {31'd0, branch_ex}, 32'd1);
        upd_valid = 1'b1; upd_taken = 1'b0; flush = 2'b11; inst_if = BR;
        #1;
        check("sim_pred_if_old", {31'd0, prediction_if}, 32'd1);
        tick();
        upd_valid = 1'b0; flush = 2'b00; inst_if = NOP;
        check("sim_branch_cnt", branch_cnt, 32'd11);
        check("sim_mispred_cnt", mispred_cnt, 32'd7);
        check("sim_branch_ex", {31'd0, branch_ex}, 32'd0);
        tick();
        check("sim_id_cleared", {31'd0, branch_ex}, 32'd0);
        inst_if = BR;
        #1;
        check("sim_pred_if_new", {31'd0, prediction_if}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_history_predictor.md
Name: branch_history_predictor

Overview:
- Dynamic branch predictor for the 5-stage RV32 pipeline; sits upstream of the EX-stage branch-resolution logic and supplies the `prediction` bit it consumes.
- At IF, looks up a table of 2-bit saturating counters indexed by PC and gives an immediate taken/not-taken guess for conditional branches (opcode 1100011).
- Carries each guess and its table index through ID to EX.
- Trains the counter at EX resolution and keeps branch/mispredict statistics.

Parameters:
IDX_BITS, 6, log2 of table entries (64 counters); index = pc_if[IDX_BITS+1:2]
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_if  in  32  PC of instruction in IF
inst_if  in  32  fetched instruction word
stall  in  1  hazard stall: IF/ID holds, bubble into EX
flush  in  2  pipeline flush from resolution logic; any nonzero value kills ID and EX
prediction_if  out  1  combinational guess for the IF instruction (drives next-PC select)
prediction  out  1  registered guess for the instruction now in EX
branch_ex  out  1  EX slot holds a valid predicted branch
upd_valid  in  1  EX resolved a conditional branch this cycle
upd_taken  in  1  actual outcome of that branch
branch_cnt  out  CNT_W  resolved branches counted
mispred_cnt  out  CNT_W  mispredictions counted

Behaviour:
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken = counter MSB.
- Reset (asynchronous, rst=1):
  - All counters = 01.
  - ID and EX stage registers cleared (valid=0, pred=0, idx=0).
  - branch_cnt = mispred_cnt = 0.
  - Outputs: prediction=0, branch_ex=0; prediction_if follows the table (0 after reset).
  - Reset mid-operation discards all in-flight state immediately.
- IF lookup (combinational, 0 latency):
  - is_br = (inst_if[6:0] == 7'b1100011).
  - prediction_if = is_br & table[idx_if][1]. Non-branches always predict 0.
- Stage registers {valid, pred, idx}: ID captures IF, EX captures ID. Priority at each rising edge:
  1. flush != 0 → ID.valid=0, EX.valid=0.
  2. else stall → ID holds, EX.valid=0 (bubble).
  3. else ID ← {is_br, prediction_if, idx_if}, EX ← ID.
- Outputs from EX stage: prediction = EX.valid & EX.pred; branch_ex = EX.valid.
- Training, at the rising edge when upd_valid & EX.valid:
  - table[EX.idx] += 1 if upd_taken, saturating at 11; -= 1 otherwise, saturating at 00.
  - branch_cnt += 1.
  - mispred_cnt += 1 iff upd_taken != EX.pred.
  - upd_valid with EX.valid=0 is ignored: no table or counter change.
- Statistics counters wrap modulo 2^CNT_W.
- Simultaneous events:
  - Update and flush in the same cycle: the update still uses the pre-edge EX contents and is applied; the flush then clears the stages.
  - IF lookup and update to the same index in the same cycle: IF sees the pre-update value (no bypass).
  - Aliased PCs sharing an index share a counter (no tags).
- Single clock domain; no multicycle paths.

Decomposition:
- Shared package holds:
  - OPC_BRANCH = 7'b1100011.
  - Counter state constants SNT/WNT/WT/ST.
  - A typedef for the stage-register struct {valid, pred, idx}.
- One natural sub-module: sat_counter2, a 2-bit saturating up/down next-state function instantiated per table write path.

Test Plan:
1. Reset mid-run with rst high for 1 cycle → all outputs 0; a branch at pc 0x100 then predicts 0 (counter 01).
2. Branch at 0x100 resolved taken twice (no stalls) → counter 01→10→11; third fetch gives prediction_if=1 and prediction=1 two cycles later; branch_cnt=2, mispred_cnt=1.
3. From state 11, four not-taken resolutions → counter 11→10→01→00→00 (saturates); mispred_cnt increments only on the first two.
4. Non-branch inst_if=0x00000013 at any PC → prediction_if=0, branch_ex=0; upd_valid pulsed → counters unchanged.
5. Branch in ID with stall=1 for 2 cycles → EX shows bubbles (branch_ex=0); the branch reaches EX the cycle after stall drops. flush=2'b11 with a branch in ID → it never reaches EX.
6. upd_valid with flush=2'b11 and lookup of the same index in one cycle → table updated, IF sees old value, ID/EX cleared next cycle.
